// File: rtl/io_input_conditioner_if.sv
// Bus bundle between board IO pads and the input conditioner.
// IO_COND_IRQ_EN adds the interrupt mask input and the irq output.
interface io_input_conditioner_if #(
    parameter int unsigned CHANNELS = 14
);
    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic [CHANNELS-1:0] event_flags;
    logic [CHANNELS-1:0] event_clear;
`ifdef IO_COND_IRQ_EN
    logic [CHANNELS-1:0] irq_mask;
    logic                irq;

    // Core side: drives pads/clears/mask, consumes conditioned levels and irq
    modport master (
        output raw_in, event_clear, irq_mask,
        input  level_out, rise_pulse, fall_pulse, event_flags, irq
    );

    modport slave (
        input  raw_in, event_clear, irq_mask,
        output level_out, rise_pulse, fall_pulse, event_flags, irq
    );
`else
    modport master (
        output raw_in, event_clear,
        input  level_out, rise_pulse, fall_pulse, event_flags
    );

    modport slave (
        input  raw_in, event_clear,
        output level_out, rise_pulse, fall_pulse, event_flags
    );
`endif
endinterface

// File: rtl/io_input_conditioner.sv
// Per-channel synchroniser, polarity normalisation, debounce, edge pulses and sticky event flags.
// Define IO_COND_IRQ_EN to add the masked, registered interrupt output.
module io_input_conditioner #(
    parameter int unsigned         CHANNELS        = 14,
    parameter int unsigned         SYNC_STAGES     = 2,
    parameter int unsigned         DEBOUNCE_CYCLES = 50000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = CHANNELS'(14'h3C00)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    io_input_conditioner_if.slave  bus
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_c;
    logic [CHANNELS-1:0] differs_c;
    logic [CHANNELS-1:0] done_c;
    logic [CHANNELS-1:0] rise_set_c;

    state_e              state_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] flag_q;

    // Polarity is normalised ahead of the first flop so every later stage is active-high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.raw_in ^ ACTIVE_LOW_MASK;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_c = sync_q[SYNC_STAGES-1];

    always_comb begin
        differs_c  = sync_c ^ level_q;
        done_c     = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            done_c[i] = differs_c[i] && (cnt_q[i] == CNT_LAST);
        end
        rise_set_c = done_c & sync_c;
    end

    // Debounce FSM per channel: any disagreement before the count completes restarts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                unique case (state_q[i])
                    ST_STABLE: begin
                        if (done_c[i]) begin
                            level_q[i] <= sync_c[i];
                            rise_q[i]  <= sync_c[i];
                            fall_q[i]  <= ~sync_c[i];
                            cnt_q[i]   <= '0;
                        end else if (differs_c[i]) begin
                            cnt_q[i]   <= CNT_W'(1);
                            state_q[i] <= ST_PENDING;
                        end else begin
                            cnt_q[i]   <= '0;
                        end
                    end
                    ST_PENDING: begin
                        if (!differs_c[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= ST_STABLE;
                        end else if (done_c[i]) begin
                            level_q[i] <= sync_c[i];
                            rise_q[i]  <= sync_c[i];
                            fall_q[i]  <= ~sync_c[i];
                            cnt_q[i]   <= '0;
                            state_q[i] <= ST_STABLE;
                        end else begin
                            cnt_q[i]   <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Sticky flags: a rise on the same edge as a clear keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q <= '0;
        end else begin
            flag_q <= rise_set_c | (flag_q & ~bus.event_clear);
        end
    end

    assign bus.level_out   = level_q;
    assign bus.rise_pulse  = rise_q;
    assign bus.fall_pulse  = fall_q;
    assign bus.event_flags = flag_q;

`ifdef IO_COND_IRQ_EN
    logic irq_q;

    // Built from the registered flags, so irq trails the flag by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(flag_q & bus.irq_mask);
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner (4 channels, 2 sync stages, debounce 4, ch3 active-low).
// Irq checks are included when IO_COND_IRQ_EN is defined.
module tb_io_input_conditioner;

    localparam int K_LEVEL = 0;
    localparam int K_RISE  = 1;
    localparam int K_FALL  = 2;
    localparam int K_FLAGS = 3;
    localparam int K_IRQ   = 4;

    typedef struct {
        int         at_edge;
        string      tag;
        int         kind;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q [$];

    io_input_conditioner_if #(.CHANNELS(4)) bus ();

    io_input_conditioner #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW_MASK (4'b1000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int e, input string tag, input int kind, input logic [3:0] v);
        exp_t x;
        x.at_edge = e;
        x.tag     = tag;
        x.kind    = kind;
        x.val     = v;
        exp_q.push_back(x);
    endtask

    task automatic to_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Count rising edges; compare due expectations 1 ns after each edge
    always begin : monitor
        exp_t       e;
        logic [3:0] got;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        while (exp_q.size() > 0 && exp_q[0].at_edge <= cyc) begin
            e = exp_q.pop_front();
            got = 4'b0000;
            case (e.kind)
                K_LEVEL: got = bus.level_out;
                K_RISE:  got = bus.rise_pulse;
                K_FALL:  got = bus.fall_pulse;
                K_FLAGS: got = bus.event_flags;
`ifdef IO_COND_IRQ_EN
                K_IRQ:   got = {3'b000, bus.irq};
`endif
                default: got = 4'bxxxx;
            endcase
            check_eq(e.tag, 32'(got), 32'(e.val));
        end
    end

    initial begin : stim
        int b;
        int r;
        bus.raw_in      = 4'b1000;
        bus.event_clear = 4'b0000;
`ifdef IO_COND_IRQ_EN
        bus.irq_mask    = 4'b0001;
        expect_at(2, "rst_irq", K_IRQ, 4'b0000);
`endif
        expect_at(2, "rst_level", K_LEVEL, 4'b0000);
        expect_at(2, "rst_rise",  K_RISE,  4'b0000);
        expect_at(2, "rst_fall",  K_FALL,  4'b0000);
        expect_at(2, "rst_flags", K_FLAGS, 4'b0000);
        to_neg(3);
        reset_n = 1'b1;

        // Clean rise on channel 0; ch3 held inactive through reset stays low
        to_neg(5);
        b = cyc;
        bus.raw_in = 4'b1001;
        expect_at(b + 3, "t1_lvl3", K_LEVEL, 4'b0000);
        expect_at(b + 5, "t1_lvl5", K_LEVEL, 4'b0000);
        expect_at(b + 5, "t1_rise5", K_RISE, 4'b0000);
        expect_at(b + 6, "t1_lvl6", K_LEVEL, 4'b0001);
        expect_at(b + 6, "t1_rise6", K_RISE, 4'b0001);
        expect_at(b + 6, "t1_flag6", K_FLAGS, 4'b0001);
        expect_at(b + 7, "t1_rise7", K_RISE, 4'b0000);
        expect_at(b + 7, "t1_lvl7", K_LEVEL, 4'b0001);

        // Short pulse on channel 1 never qualifies
        to_neg(b + 8);
        b = cyc;
        bus.raw_in = 4'b1011;
        for (int k = 1; k <= 10; k++) expect_at(b + k, "t2_lvl", K_LEVEL, 4'b0001);
        expect_at(b + 10, "t2_rise", K_RISE, 4'b0000);
        expect_at(b + 10, "t2_flag", K_FLAGS, 4'b0001);
        to_neg(b + 3);
        bus.raw_in = 4'b1001;

        // Active-low channel 3: press then release
        to_neg(b + 12);
        b = cyc;
        bus.raw_in = 4'b0001;
        expect_at(b + 5, "t3_lvl5", K_LEVEL, 4'b0001);
        expect_at(b + 6, "t3_lvl6", K_LEVEL, 4'b1001);
        expect_at(b + 6, "t3_rise6", K_RISE, 4'b1000);
        expect_at(b + 6, "t3_flag6", K_FLAGS, 4'b1001);
        expect_at(b + 7, "t3_rise7", K_RISE, 4'b0000);
        to_neg(b + 8);
        b = cyc;
        bus.raw_in = 4'b1001;
        expect_at(b + 5, "t3_fall5", K_FALL, 4'b0000);
        expect_at(b + 5, "t3_lvlr5", K_LEVEL, 4'b1001);
        expect_at(b + 6, "t3_fall6", K_FALL, 4'b1000);
        expect_at(b + 6, "t3_lvlr6", K_LEVEL, 4'b0001);
        expect_at(b + 7, "t3_fall7", K_FALL, 4'b0000);

        // Clear all flags, then set-vs-clear collision on channel 0
        to_neg(b + 9);
        b = cyc;
        bus.event_clear = 4'b1111;
        expect_at(b + 1, "t4_clrall", K_FLAGS, 4'b0000);
        to_neg(b + 1);
        bus.event_clear = 4'b0000;
        b = cyc;
        bus.raw_in = 4'b1000;
        expect_at(b + 6, "t4_lvl0", K_LEVEL, 4'b0000);
        expect_at(b + 6, "t4_fall", K_FALL, 4'b0001);
        expect_at(b + 7, "t4_fall7", K_FALL, 4'b0000);
        to_neg(b + 8);
        b = cyc;
        bus.raw_in = 4'b1001;
        expect_at(b + 5, "t4_flag5", K_FLAGS, 4'b0000);
        expect_at(b + 6, "t4_setwin", K_FLAGS, 4'b0001);
        expect_at(b + 6, "t4_rise", K_RISE, 4'b0001);
        expect_at(b + 7, "t4_clr", K_FLAGS, 4'b0000);
        to_neg(b + 5);
        bus.event_clear = 4'b0001;
        to_neg(b + 7);
        bus.event_clear = 4'b0000;

        // Reset mid-count on channel 2; ch0 and ch2 re-qualify together afterwards
        to_neg(b + 9);
        b = cyc;
        bus.raw_in = 4'b1101;
        expect_at(b + 4, "t5_pre", K_LEVEL, 4'b0001);
        expect_at(b + 5, "t5_rlvl", K_LEVEL, 4'b0000);
        expect_at(b + 5, "t5_rrise", K_RISE, 4'b0000);
        expect_at(b + 5, "t5_rfall", K_FALL, 4'b0000);
        expect_at(b + 5, "t5_rflag", K_FLAGS, 4'b0000);
`ifdef IO_COND_IRQ_EN
        expect_at(b + 5, "t5_rirq", K_IRQ, 4'b0000);
`endif
        to_neg(b + 4);
        reset_n = 1'b0;
        to_neg(b + 6);
        reset_n = 1'b1;
        r = cyc;
        expect_at(r + 5, "t5_lvl5", K_LEVEL, 4'b0000);
        expect_at(r + 6, "t5_lvl6", K_LEVEL, 4'b0101);
        expect_at(r + 6, "t5_rise6", K_RISE, 4'b0101);
        expect_at(r + 6, "t5_fall6", K_FALL, 4'b0000);
        expect_at(r + 6, "t5_flag6", K_FLAGS, 4'b0101);
`ifdef IO_COND_IRQ_EN
        expect_at(r + 6, "t6_irq6", K_IRQ, 4'b0000);
`endif
        expect_at(r + 7, "t5_rise7", K_RISE, 4'b0000);
`ifdef IO_COND_IRQ_EN
        expect_at(r + 7, "t6_irq7", K_IRQ, 4'b0001);
        expect_at(r + 8, "t6_flgclr", K_FLAGS, 4'b0100);
        expect_at(r + 8, "t6_irqhold", K_IRQ, 4'b0001);
        expect_at(r + 9, "t6_irqdrop", K_IRQ, 4'b0000);
        to_neg(r + 7);
        bus.event_clear = 4'b0001;
        to_neg(r + 8);
        bus.event_clear = 4'b0000;

        // Masked channel 1 event alone keeps irq low
        b = cyc;
        bus.raw_in = 4'b1111;
        expect_at(b + 6, "t6_ch1flag", K_FLAGS, 4'b0110);
        expect_at(b + 7, "t6_ch1irq7", K_IRQ, 4'b0000);
        expect_at(b + 8, "t6_ch1irq8", K_IRQ, 4'b0000);
        to_neg(b + 9);
        bus.raw_in = 4'b1110;
        b = cyc;
        to_neg(b + 8);
        b = cyc;
        bus.raw_in = 4'b1111;
        expect_at(b + 6, "t6_ch0flag", K_FLAGS, 4'b0111);
        expect_at(b + 6, "t6_ch0irq6", K_IRQ, 4'b0000);
        expect_at(b + 7, "t6_ch0irq7", K_IRQ, 4'b0001);
        to_neg(b + 9);
`else
        to_neg(r + 9);
`endif
        to_neg(cyc + 2);
        check_eq("leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
